// File: rtl/video_clk_gen.sv
// video_clk_gen: NUM_CLOCKS fractional-rate clock-enable generators (NCO
// phase accumulators) running on one reference clock, with runtime-
// reprogrammable increments and a settle/lock state machine.
//
// Ports:
//   refclk    - single clock for all logic
//   rst       - synchronous active-high reset
//   cfg_valid - reconfiguration request
//   cfg_ready - request can be accepted (high only while LOCKED)
//   cfg_sel   - channel index to reprogram
//   cfg_inc   - new increment for that channel
//   clk_en    - one-cycle enable pulse per channel period (accumulator carry)
//   clk_out   - divided square clock (accumulator MSB)
//   locked    - outputs stable and phase-aligned
module video_clk_gen #(
  parameter int unsigned NUM_CLOCKS  = 2,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter logic [NUM_CLOCKS*ACC_WIDTH-1:0] INC_INIT = {32'h6666_6666, 32'h8000_0000},
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned SEL_W       = 3
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic [ACC_WIDTH-1:0]  cfg_inc,
  output logic [NUM_CLOCKS-1:0] clk_en,
  output logic [NUM_CLOCKS-1:0] clk_out,
  output logic                  locked
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_LOCKED = 2'd1,
    ST_APPLY  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [ACC_WIDTH-1:0]  inc_new_q, inc_new_d;
  logic                  locked_q, locked_d;
  logic                  ready_q, ready_d;
  logic [NUM_CLOCKS-1:0] clk_en_q, clk_en_d;
  logic [NUM_CLOCKS-1:0] clk_out_q, clk_out_d;
  logic [ACC_WIDTH-1:0]  acc_q [NUM_CLOCKS];
  logic [ACC_WIDTH-1:0]  acc_d [NUM_CLOCKS];
  logic [ACC_WIDTH-1:0]  inc_q [NUM_CLOCKS];
  logic [ACC_WIDTH-1:0]  inc_d [NUM_CLOCKS];
  logic [ACC_WIDTH:0]    sum_c [NUM_CLOCKS];
  logic                  run_c;

  // State register and datapath registers.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_SETTLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      inc_new_q <= '0;
      locked_q  <= 1'b0;
      ready_q   <= 1'b0;
      clk_en_q  <= '0;
      clk_out_q <= '0;
      for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= INC_INIT[i*ACC_WIDTH +: ACC_WIDTH];
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      inc_new_q <= inc_new_d;
      locked_q  <= locked_d;
      ready_q   <= ready_d;
      clk_en_q  <= clk_en_d;
      clk_out_q <= clk_out_d;
      for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
      end
    end
  end

  // Next-state logic, handshake and per-channel accumulator update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    inc_new_d = inc_new_q;
    locked_d  = locked_q;
    ready_d   = ready_q;
    clk_en_d  = clk_en_q;
    clk_out_d = clk_out_q;
    run_c     = 1'b0;
    for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
      acc_d[i] = acc_q[i];
      inc_d[i] = inc_q[i];
      sum_c[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
    end

    case (state_q)
      ST_SETTLE: begin
        run_c = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
          state_d  = ST_LOCKED;
          locked_d = 1'b1;
          ready_d  = 1'b1;
        end
      end
      ST_LOCKED: begin
        run_c = 1'b1;
        // Out-of-range selects complete the handshake without effect.
        if (cfg_valid && ready_q && (32'(cfg_sel) < NUM_CLOCKS)) begin
          sel_d     = cfg_sel;
          inc_new_d = cfg_inc;
          state_d   = ST_APPLY;
          locked_d  = 1'b0;
          ready_d   = 1'b0;
        end
      end
      ST_APPLY: begin
        // Load the new rate and restart every channel from phase zero.
        for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
          acc_d[i] = '0;
          if (sel_q == SEL_W'(i)) inc_d[i] = inc_new_q;
        end
        clk_en_d  = '0;
        clk_out_d = '0;
        cnt_d     = '0;
        state_d   = ST_SETTLE;
      end
      default: begin
        state_d = ST_SETTLE;
      end
    endcase

    // Carry out is the enable pulse; MSB of the sum is the square clock.
    if (run_c) begin
      for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
        acc_d[i]     = sum_c[i][ACC_WIDTH-1:0];
        clk_en_d[i]  = sum_c[i][ACC_WIDTH];
        clk_out_d[i] = sum_c[i][ACC_WIDTH-1];
      end
    end
  end

  assign cfg_ready = ready_q;
  assign locked    = locked_q;
  assign clk_en    = clk_en_q;
  assign clk_out   = clk_out_q;

endmodule

// File: tb/tb_video_clk_gen.sv
// Directed self-checking bench for video_clk_gen (default 2-channel/32-bit
// instance plus a 1-channel/8-bit instance for the wrap/carry pattern).
module tb_video_clk_gen;

  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_sel = '0;
  logic [31:0] cfg_inc = '0;
  logic [1:0]  clk_en;
  logic [1:0]  clk_out;
  logic        locked;

  logic        rst8 = 1'b1;
  logic        cfg_valid8 = 1'b0;
  logic        cfg_ready8;
  logic [2:0]  cfg_sel8 = '0;
  logic [7:0]  cfg_inc8 = '0;
  logic [0:0]  clk_en8;
  logic [0:0]  clk_out8;
  logic        locked8;

  int n_checks = 0;
  int n_pass = 0;

  always #5 refclk = ~refclk;

  video_clk_gen u_dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_inc(cfg_inc), .clk_en(clk_en), .clk_out(clk_out),
    .locked(locked)
  );

  video_clk_gen #(
    .NUM_CLOCKS(1), .ACC_WIDTH(8), .INC_INIT(8'hFF), .LOCK_CYCLES(16), .SEL_W(3)
  ) u_dut8 (
    .refclk(refclk), .rst(rst8), .cfg_valid(cfg_valid8), .cfg_ready(cfg_ready8),
    .cfg_sel(cfg_sel8), .cfg_inc(cfg_inc8), .clk_en(clk_en8), .clk_out(clk_out8),
    .locked(locked8)
  );

  // Advance one edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    repeat (3) tick();
    n_checks++; if (clk_en !== 2'b00) $display("FAIL reset_clk_en got=%b exp=00", clk_en); else n_pass++;
    n_checks++; if (clk_out !== 2'b00) $display("FAIL reset_clk_out got=%b exp=00", clk_out); else n_pass++;
    n_checks++; if (locked !== 1'b0) $display("FAIL reset_locked got=%b exp=0", locked); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL reset_cfg_ready got=%b exp=0", cfg_ready); else n_pass++;
    rst = 1'b0;
  endtask

  // ch1 increment 0x6666_6666 is a hair below 0.4, so every carry that would
  // land on a multiple of 5 arrives one edge late: 39 pulses in edges 1..100,
  // 40 in edges 101..200, first pulse on edge 3.
  task automatic test_default_rates();
    int p_lo = 0;
    int p_hi = 0;
    for (int e = 1; e <= 200; e++) begin
      tick();
      n_checks++; if (clk_en[0] !== ((e % 2) == 0)) $display("FAIL def_ch0_en e=%0d got=%b", e, clk_en[0]); else n_pass++;
      n_checks++; if (clk_out[0] !== ((e % 2) == 1)) $display("FAIL def_ch0_out e=%0d got=%b", e, clk_out[0]); else n_pass++;
      n_checks++; if (locked !== (e >= 16)) $display("FAIL def_locked e=%0d got=%b", e, locked); else n_pass++;
      n_checks++; if (cfg_ready !== (e >= 16)) $display("FAIL def_ready e=%0d got=%b", e, cfg_ready); else n_pass++;
      if (e == 2) begin
        n_checks++; if (clk_en[1] !== 1'b0) $display("FAIL def_ch1_e2 got=%b exp=0", clk_en[1]); else n_pass++;
      end
      if (e == 3) begin
        n_checks++; if (clk_en[1] !== 1'b1) $display("FAIL def_ch1_e3 got=%b exp=1", clk_en[1]); else n_pass++;
      end
      if (e <= 100) p_lo += int'(clk_en[1]); else p_hi += int'(clk_en[1]);
    end
    n_checks++; if (p_lo != 39) $display("FAIL def_ch1_cnt_lo got=%0d exp=39", p_lo); else n_pass++;
    n_checks++; if (p_hi != 40) $display("FAIL def_ch1_cnt_hi got=%0d exp=40", p_hi); else n_pass++;
  endtask

  task automatic test_reconfig();
    cfg_valid = 1'b1; cfg_sel = 3'd1; cfg_inc = 32'h4000_0000;
    tick();
    cfg_valid = 1'b0;
    n_checks++; if (locked !== 1'b0) $display("FAIL rcfg_locked_k got=%b exp=0", locked); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL rcfg_ready_k got=%b exp=0", cfg_ready); else n_pass++;
    tick();
    n_checks++; if (clk_en !== 2'b00) $display("FAIL rcfg_apply_en got=%b exp=00", clk_en); else n_pass++;
    n_checks++; if (clk_out !== 2'b00) $display("FAIL rcfg_apply_out got=%b exp=00", clk_out); else n_pass++;
    n_checks++; if (locked !== 1'b0) $display("FAIL rcfg_apply_locked got=%b exp=0", locked); else n_pass++;
    for (int j = 2; j <= 40; j++) begin
      tick();
      n_checks++; if (locked !== (j >= 17)) $display("FAIL rcfg_locked j=%0d got=%b", j, locked); else n_pass++;
      n_checks++; if (clk_en[1] !== (((j - 1) % 4) == 0)) $display("FAIL rcfg_ch1_en j=%0d got=%b", j, clk_en[1]); else n_pass++;
      n_checks++; if (clk_en[0] !== ((j % 2) == 1)) $display("FAIL rcfg_ch0_en j=%0d got=%b", j, clk_en[0]); else n_pass++;
    end
  endtask

  task automatic test_invalid_sel();
    int c0 = 0;
    int c1 = 0;
    cfg_valid = 1'b1; cfg_sel = 3'd5; cfg_inc = 32'h0;
    tick();
    cfg_valid = 1'b0;
    n_checks++; if (locked !== 1'b1) $display("FAIL bad_sel_locked got=%b exp=1", locked); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1) $display("FAIL bad_sel_ready got=%b exp=1", cfg_ready); else n_pass++;
    for (int j = 0; j < 8; j++) begin
      tick();
      c0 += int'(clk_en[0]);
      c1 += int'(clk_en[1]);
    end
    n_checks++; if (c0 != 4) $display("FAIL bad_sel_ch0_cnt got=%0d exp=4", c0); else n_pass++;
    n_checks++; if (c1 != 2) $display("FAIL bad_sel_ch1_cnt got=%0d exp=2", c1); else n_pass++;
    n_checks++; if (locked !== 1'b1) $display("FAIL bad_sel_locked_end got=%b exp=1", locked); else n_pass++;
  endtask

  // Rewrite ch0 with its current value, then hold a ch1 request through
  // APPLY/SETTLE; it must be taken on the first LOCKED edge.
  task automatic test_hold_valid_settle();
    int c0 = 0;
    int c1 = 0;
    cfg_valid = 1'b1; cfg_sel = 3'd0; cfg_inc = 32'h8000_0000;
    tick();
    n_checks++; if (locked !== 1'b0) $display("FAIL hold_same_inc_relock got=%b exp=0", locked); else n_pass++;
    cfg_sel = 3'd1; cfg_inc = 32'h2000_0000;
    for (int j = 1; j <= 18; j++) begin
      tick();
      n_checks++; if (locked !== (j == 17)) $display("FAIL hold_locked j=%0d got=%b", j, locked); else n_pass++;
      n_checks++; if (cfg_ready !== (j == 17)) $display("FAIL hold_ready j=%0d got=%b", j, cfg_ready); else n_pass++;
    end
    cfg_valid = 1'b0;
    repeat (17) tick();
    n_checks++; if (locked !== 1'b1) $display("FAIL hold_relocked got=%b exp=1", locked); else n_pass++;
    for (int j = 0; j < 16; j++) begin
      tick();
      c0 += int'(clk_en[0]);
      c1 += int'(clk_en[1]);
    end
    n_checks++; if (c0 != 8) $display("FAIL hold_ch0_cnt got=%0d exp=8", c0); else n_pass++;
    n_checks++; if (c1 != 2) $display("FAIL hold_ch1_cnt got=%0d exp=2", c1); else n_pass++;
  endtask

  task automatic test_reset_mid_settle();
    int c1 = 0;
    cfg_valid = 1'b1; cfg_sel = 3'd1; cfg_inc = 32'h4000_0000;
    tick();
    cfg_sel = 3'd1; cfg_inc = 32'h1000_0000;
    repeat (5) tick();
    n_checks++; if (locked !== 1'b0) $display("FAIL rstmid_settling got=%b exp=0", locked); else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++; if (clk_en !== 2'b00) $display("FAIL rstmid_en got=%b exp=00", clk_en); else n_pass++;
    n_checks++; if (clk_out !== 2'b00) $display("FAIL rstmid_out got=%b exp=00", clk_out); else n_pass++;
    n_checks++; if (locked !== 1'b0) $display("FAIL rstmid_locked got=%b exp=0", locked); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b0) $display("FAIL rstmid_ready got=%b exp=0", cfg_ready); else n_pass++;
    rst = 1'b0;
    cfg_valid = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      tick();
      n_checks++; if (locked !== (e >= 16)) $display("FAIL rstmid_relock e=%0d got=%b", e, locked); else n_pass++;
      n_checks++; if (clk_en[0] !== ((e % 2) == 0)) $display("FAIL rstmid_ch0 e=%0d got=%b", e, clk_en[0]); else n_pass++;
      if (e == 3) begin
        n_checks++; if (clk_en[1] !== 1'b1) $display("FAIL rstmid_ch1_e3 got=%b exp=1", clk_en[1]); else n_pass++;
      end
      c1 += int'(clk_en[1]);
    end
    n_checks++; if (c1 != 39) $display("FAIL rstmid_ch1_cnt got=%0d exp=39", c1); else n_pass++;
  endtask

  task automatic test_zero_inc();
    int c1 = 0;
    cfg_valid = 1'b1; cfg_sel = 3'd0; cfg_inc = 32'h0;
    tick();
    cfg_valid = 1'b0;
    for (int j = 1; j <= 60; j++) begin
      tick();
      n_checks++; if (clk_en[0] !== 1'b0) $display("FAIL zero_ch0_en j=%0d got=%b", j, clk_en[0]); else n_pass++;
      n_checks++; if (clk_out[0] !== 1'b0) $display("FAIL zero_ch0_out j=%0d got=%b", j, clk_out[0]); else n_pass++;
      n_checks++; if (locked !== (j >= 17)) $display("FAIL zero_locked j=%0d got=%b", j, locked); else n_pass++;
      if (j >= 2 && j <= 51) c1 += int'(clk_en[1]);
    end
    n_checks++; if (c1 != 19) $display("FAIL zero_ch1_cnt got=%0d exp=19", c1); else n_pass++;
  endtask

  // 8-bit accumulator with inc 0xFF: carry on every edge except when the
  // accumulator passes through zero (edges 1 and 257).
  task automatic test_width8();
    int c = 0;
    rst8 = 1'b0;
    for (int e = 1; e <= 257; e++) begin
      tick();
      if (e <= 256) c += int'(clk_en8[0]);
      if (e == 1 || e == 257) begin
        n_checks++; if (clk_en8[0] !== 1'b0) $display("FAIL w8_en e=%0d got=%b exp=0", e, clk_en8[0]); else n_pass++;
      end
      if (e == 2) begin
        n_checks++; if (clk_en8[0] !== 1'b1) $display("FAIL w8_en e=2 got=%b exp=1", clk_en8[0]); else n_pass++;
      end
      if (e == 15 || e == 16) begin
        n_checks++; if (locked8 !== (e == 16)) $display("FAIL w8_locked e=%0d got=%b", e, locked8); else n_pass++;
      end
    end
    n_checks++; if (c != 255) $display("FAIL w8_cnt got=%0d exp=255", c); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_default_rates();
    test_reconfig();
    test_invalid_sel();
    test_hold_valid_settle();
    test_reset_mid_settle();
    test_zero_inc();
    test_width8();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
